// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, matrix
// dimensions, key_code field layout and small helper functions.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int ROW_W    = 2;
    localparam int COL_W    = 2;
    localparam int CODE_W   = ROW_W + COL_W;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // key_code layout: row in the upper bits, column in the lower bits.
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } key_code_t;

    // Index of the lowest-numbered low (pressed) column; 0 if none is low.
    function automatic logic [COL_W-1:0] first_low_col(input logic [NUM_COLS-1:0] cols);
        first_low_col = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) first_low_col = i[COL_W-1:0];
        end
    endfunction

    // Row drive pattern: selected row low, all others high.
    function automatic logic [NUM_ROWS-1:0] row_drive(input logic [ROW_W-1:0] row);
        row_drive = ~(NUM_ROWS'(1) << row);
    endfunction

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event bus from the scanner to its consumer.
// key_valid is a one-cycle strobe with no back-pressure (no ready): the
// consumer must take key_code in the cycle key_valid is high. key_code is
// held stable between strobes; key_down is a level, high while a confirmed
// key is held.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_down;

    modport master (output key_valid, output key_code, output key_down);
    modport slave  (input  key_valid, input  key_code, input  key_down);

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up column inputs.
// Both stages reset high so an idle keypad reads as "no key" immediately.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic                hwclk,
    input  logic                hwrst_n,
    input  logic [NUM_COLS-1:0] cols_in,
    output logic [NUM_COLS-1:0] cols_s
);

    logic [NUM_COLS-1:0] meta;

    // Two register stages in series to settle metastability.
    always_ff @(posedge hwclk or negedge hwrst_n) begin
        if (!hwrst_n) begin
            meta   <= '1;
            cols_s <= '1;
        end else begin
            meta   <= cols_in;
            cols_s <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and single-key capture.
// Optional auto-repeat while a key is held: define KEYPAD_SCANNER_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned DEBOUNCE_PERIOD = 120000,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 1200000
) (
    input  logic                hwclk,
    input  logic                hwrst_n,
    output logic [NUM_ROWS-1:0] keypad_r,
    input  logic [NUM_COLS-1:0] keypad_c,
    keypad_scanner_if.master    key_bus,
    output state_t              dbg_state
);

    logic [NUM_COLS-1:0] cols_s;
    state_t              state, state_n;
    logic [ROW_W-1:0]    row, row_n;
    logic [COL_W-1:0]    col, col_n;
    logic [31:0]         cnt, cnt_n;
    logic                key_valid_q, key_valid_n;
    key_code_t           key_code_q, key_code_n;
    logic                key_down_q, key_down_n;
    logic                col_low;

`ifdef KEYPAD_SCANNER_REPEAT_EN
    logic [31:0]         rep_cnt, rep_cnt_n;
    logic                rep_first, rep_first_n;
`else
    // Repeat timing has no effect in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    keypad_sync u_sync (
        .hwclk   (hwclk),
        .hwrst_n (hwrst_n),
        .cols_in (keypad_c),
        .cols_s  (cols_s)
    );

    assign col_low           = !cols_s[col];
    assign key_bus.key_valid = key_valid_q;
    assign key_bus.key_code  = key_code_q;
    assign key_bus.key_down  = key_down_q;
    assign dbg_state         = state;

    // Next-state and output decode for the scan/debounce/hold/release FSM.
    always_comb begin
        state_n     = state;
        row_n       = row;
        col_n       = col;
        cnt_n       = cnt;
        key_valid_n = 1'b0;
        key_code_n  = key_code_q;
        key_down_n  = key_down_q;
`ifdef KEYPAD_SCANNER_REPEAT_EN
        rep_cnt_n   = rep_cnt;
        rep_first_n = rep_first;
`endif
        case (state)
            SCAN: begin
                if (cnt >= 32'(SETTLE_CYCLES)) begin
                    cnt_n = '0;
                    if (&cols_s) begin
                        row_n = row + 1'b1;
                    end else begin
                        col_n   = first_low_col(cols_s);
                        state_n = DEBOUNCE;
                    end
                end else begin
                    cnt_n = sat_inc(cnt);
                end
            end
            DEBOUNCE: begin
                if (!col_low) begin
                    // Bounce: rescan the same row without reporting.
                    state_n = SCAN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = sat_inc(cnt);
                    if (cnt_n >= 32'(DEBOUNCE_PERIOD)) begin
                        state_n     = HELD;
                        cnt_n       = '0;
                        key_valid_n = 1'b1;
                        key_code_n  = '{row: row, col: col};
                        key_down_n  = 1'b1;
`ifdef KEYPAD_SCANNER_REPEAT_EN
                        rep_cnt_n   = '0;
                        rep_first_n = 1'b1;
`endif
                    end
                end
            end
            HELD: begin
                if (!col_low) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                end else begin
`ifdef KEYPAD_SCANNER_REPEAT_EN
                    rep_cnt_n = sat_inc(rep_cnt);
                    if (rep_cnt_n >= (rep_first ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD))) begin
                        key_valid_n = 1'b1;
                        rep_cnt_n   = '0;
                        rep_first_n = 1'b0;
                    end
`endif
                end
            end
            RELEASE: begin
                if (col_low) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = sat_inc(cnt);
                    if (cnt_n >= 32'(DEBOUNCE_PERIOD)) begin
                        state_n    = SCAN;
                        cnt_n      = '0;
                        row_n      = row + 1'b1;
                        key_down_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = SCAN;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; the row drive follows the
    // next row so row 0 appears on the first clock after reset.
    always_ff @(posedge hwclk or negedge hwrst_n) begin
        if (!hwrst_n) begin
            state       <= SCAN;
            row         <= '0;
            col         <= '0;
            cnt         <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_down_q  <= 1'b0;
            keypad_r    <= '1;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            state       <= state_n;
            row         <= row_n;
            col         <= col_n;
            cnt         <= cnt_n;
            key_valid_q <= key_valid_n;
            key_code_q  <= key_code_n;
            key_down_q  <= key_down_n;
            keypad_r    <= row_drive(row_n);
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rep_cnt     <= rep_cnt_n;
            rep_first   <= rep_first_n;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with a small keypad matrix model.
// Define KEYPAD_SCANNER_REPEAT_EN to exercise the auto-repeat build.
module tb_keypad_scanner;
    import keypad_pkg::*;

    // ---------------- clock / reset ----------------
    logic       hwclk   = 1'b0;
    logic       hwrst_n = 1'b0;
    logic [3:0] keypad_r;
    logic [3:0] keypad_c;
    state_t     dbg_state;
    logic [3:0] key_mat [4];   // key_mat[row][col] = 1 -> key pressed

    always #5 hwclk = ~hwclk;

    keypad_scanner_if key_bus ();

    keypad_scanner #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_PERIOD (20),
        .REPEAT_DELAY    (100),
        .REPEAT_PERIOD   (30)
    ) dut (
        .hwclk     (hwclk),
        .hwrst_n   (hwrst_n),
        .keypad_r  (keypad_r),
        .keypad_c  (keypad_c),
        .key_bus   (key_bus),
        .dbg_state (dbg_state)
    );

    // Matrix model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        keypad_c = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!keypad_r[r] && key_mat[r][c]) keypad_c[c] = 1'b0;
    end

    // ---------------- scoreboard ----------------
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         pulse_q[$];
    logic [3:0] code_q[$];

    // Records every cycle key_valid is high (a two-cycle pulse counts twice).
    always @(negedge hwclk) begin
        cyc++;
        if (key_bus.key_valid === 1'b1) begin
            pulse_q.push_back(cyc);
            code_q.push_back(key_bus.key_code);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) key_mat[r] = 4'b0000;
    endtask

    // Waits (bounded) for key_down to drop; returns the cycles waited.
    task automatic wait_key_up(output int n);
        n = 0;
        while (key_bus.key_down === 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while (pulse_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        logic [3:0] prev;
        int changes, bad_seq, bad_per, last_chg, n;
        bit reached;

        // Watchdog so the run always ends.
        fork
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        clear_keys();
        hwrst_n = 1'b0;
        tick(3);
        check("rst_keypad_r", keypad_r, 4'b1111);
        check("rst_key_valid", key_bus.key_valid, 1'b0);
        check("rst_key_code", key_bus.key_code, 4'b0000);
        check("rst_key_down", key_bus.key_down, 1'b0);
        check("rst_state", 32'(dbg_state), 32'(SCAN));
        hwrst_n = 1'b1;
        tick(1);
        check("first_row_after_rst", keypad_r, 4'b1110);

        // Idle scan: rotation 1110 -> 1101 -> 1011 -> 0111, one step every 5 cycles.
        tick(10);
        changes = 0; bad_seq = 0; bad_per = 0; last_chg = -1;
        for (int i = 0; i < 200; i++) begin
            prev = keypad_r;
            tick(1);
            if (keypad_r != prev) begin
                changes++;
                if (keypad_r != {prev[2:0], prev[3]}) bad_seq++;
                if (last_chg >= 0 && (i - last_chg) != 5) bad_per++;
                last_chg = i;
            end
        end
        check("idle_sequence", bad_seq, 0);
        check("idle_period", bad_per, 0);
        check("idle_changes", 32'(changes >= 39), 1);
        check("idle_no_pulse", pulse_q.size(), 0);

        // Clean press row 2 / col 1.
        pulse_q.delete(); code_q.delete();
        key_mat[2][1] = 1'b1;
        tick(60);
        check("press_pulses", pulse_q.size(), 1);
        if (code_q.size() > 0) check("press_code", code_q[0], 4'b1001);
        check("press_key_down", key_bus.key_down, 1'b1);
        clear_keys();
        wait_key_up(n);
        // 2 sync stages + 1 cycle HELD->RELEASE + 20 debounce cycles.
        check("release_delay", n, 23);
        check("release_no_extra_pulse", pulse_q.size(), 1);
        check("code_held_after_release", key_bus.key_code, 4'b1001);

        // Bouncing contact at row 0 / col 3.
        tick(5);
        pulse_q.delete(); code_q.delete();
        for (int i = 0; i < 10; i++) begin
            key_mat[0][3] = (i % 2 == 0);
            tick(5);
        end
        check("bounce_no_pulse", pulse_q.size(), 0);
        key_mat[0][3] = 1'b1;
        tick(60);
        check("bounce_pulses", pulse_q.size(), 1);
        if (code_q.size() > 0) check("bounce_code", code_q[0], 4'b0011);
        clear_keys();
        wait_key_up(n);
        check("bounce_key_up", key_bus.key_down, 1'b0);

        // Two columns low on row 1: lowest column wins.
        tick(5);
        pulse_q.delete(); code_q.delete();
        key_mat[1][0] = 1'b1;
        key_mat[1][3] = 1'b1;
        tick(60);
        check("multi_pulses", pulse_q.size(), 1);
        if (code_q.size() > 0) check("multi_code", code_q[0], 4'b0100);
        clear_keys();
        wait_key_up(n);
        check("multi_key_up", key_bus.key_down, 1'b0);

        // Long hold on row 3 / col 0: 200 cycles past confirmation.
        tick(5);
        pulse_q.delete(); code_q.delete();
        key_mat[3][0] = 1'b1;
        wait_pulses(1, 100);
        check("hold_confirmed", pulse_q.size(), 1);
        tick(200);
        clear_keys();
        wait_key_up(n);
`ifdef KEYPAD_SCANNER_REPEAT_EN
        check("repeat_count", pulse_q.size(), 5);
        if (pulse_q.size() == 5) begin
            check("repeat_1", pulse_q[1] - pulse_q[0], 100);
            check("repeat_2", pulse_q[2] - pulse_q[0], 130);
            check("repeat_3", pulse_q[3] - pulse_q[0], 160);
            check("repeat_4", pulse_q[4] - pulse_q[0], 190);
            check("repeat_code", code_q[4], 4'b1100);
        end
`else
        check("hold_single_pulse", pulse_q.size(), 1);
        if (code_q.size() > 0) check("hold_code", code_q[0], 4'b1100);
`endif

        // Reset asserted 10 cycles into DEBOUNCE abandons the press.
        tick(5);
        pulse_q.delete(); code_q.delete();
        key_mat[1][2] = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            tick(1);
            if (dbg_state == DEBOUNCE) reached = 1'b1;
        end
        check("reach_debounce", reached, 1'b1);
        tick(10);
        check("still_debounce", 32'(dbg_state), 32'(DEBOUNCE));
        hwrst_n = 1'b0;
        #1;
        check("midrst_keypad_r", keypad_r, 4'b1111);
        check("midrst_state", 32'(dbg_state), 32'(SCAN));
        clear_keys();
        tick(3);
        check("midrst_hold_keypad_r", keypad_r, 4'b1111);
        check("midrst_key_down", key_bus.key_down, 1'b0);
        hwrst_n = 1'b1;
        tick(1);
        check("midrst_first_row", keypad_r, 4'b1110);
        tick(50);
        check("midrst_no_pulse", pulse_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
